lfsr_checker: RTL and testbench
===============================

# lfsr_checker

Receive-side companion to the team's Fibonacci LFSR generator. It accepts the serial `data`/`valid` stream the generator emits and self-synchronizes to it from the received bits alone. Once locked, it predicts every following bit and reports bit errors, running bit/error counts and lock status. It sits at the sink of PRBS links and loopback tests, and is configured with the same `N`/`TAPS` as the generator feeding it.

## Interface
- `N`, 8: LFSR length in bits, at least 2.
- `TAPS`, 8'b00000011: feedback mask, bit i = tap on history bit i; must equal the generator's `TAPS`.
- `LOCK_COUNT`, 16: consecutive correct predictions required to declare lock, at least 1.
- `WINDOW`, 64: error-monitoring window length, in valid bits while locked.
- `ERR_THRESH`, 8: errors within one window that force loss of lock, at least 1.
- `CNT_W`, 32: width of the statistics counters.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i`, in, 1: clock, rising edge.
- `reset_i`, in, 1: asynchronous, active-high reset.
- `data_i`, in, 1: received bit, meaningful only when `valid_i` = 1.
- `valid_i`, in, 1: qualifies `data_i`; no back-pressure.
- `clear_cnt_i`, in, 1: synchronous zeroing of `bit_cnt_o` and `err_cnt_o`.
- `locked_o`, out, 1: checker is in LOCKED.
- `err_o`, out, 1: one-cycle pulse per mismatching bit while locked.
- `bit_cnt_o`, out, `CNT_W`: valid bits checked while locked, saturating.
- `err_cnt_o`, out, `CNT_W`: errors while locked, saturating.

## Operation
- History register `h[N-1:0]`: `h[0]` holds the oldest bit. Each bit shifts in as `h <= {bit, h[N-1:1]}`, matching the generator's shift register.
- Prediction `p` = XOR over i of (`h[i]` & `TAPS[i]`).
- Only cycles with `valid_i` = 1 advance any state. Cycles with `valid_i` = 0 are ignored entirely and `err_o` = 0.
- FILL state (entered from reset and on loss of lock):
  - Shift `data_i` in and count bits.
  - After the N-th bit, go to SEARCH with the match counter at 0.
- SEARCH state:
  - Compare `data_i` to `p`, then shift `data_i` in, so the checker self-synchronizes.
  - Match while `h` is nonzero: match counter +1.
  - Mismatch, or `h` all zeros: match counter := 0. The all-zero history never counts as a match, so a stuck-at-0 line cannot produce lock.
  - When the match counter reaches `LOCK_COUNT`, go to LOCKED and clear the window counters.
- LOCKED state (flywheel):
  - Shift `p` in, not `data_i`, so one line error is counted exactly once.
  - Each valid bit: `bit_cnt` +1. If `data_i` != `p`, then `err_o` = 1, `err_cnt` +1, and the window error count +1.
  - Window bit counter runs 0..`WINDOW`-1. When it wraps, the window error count := 0.
  - If the window error count reaches `ERR_THRESH`, go to FILL with the fill counter at 0. `locked_o` falls. Counters hold their values.
  - Threshold reached on the last bit of a window: loss of lock wins over the window wrap.
- Counters:
  - Saturate at all-ones and never wrap.
  - `clear_cnt_i` sets both to 0 that cycle. If an increment coincides with the clear, the clear wins and the event is not counted.
  - `err_o` still pulses for that event.
- Counters are not cleared on lock or on loss of lock; only `clear_cnt_i` and reset clear them.

## Timing
- Reset values: `locked_o` = 0, `err_o` = 0, `bit_cnt_o` = 0, `err_cnt_o` = 0, state = FILL, `h` = 0, all internal counters 0.
- Reset asserted mid-operation: everything returns to the reset values immediately, without waiting for a clock edge.
- All outputs are registered, with a latency of one cycle from the sampling edge of the relevant valid bit.
  - `err_o` is high during the cycle after the erroneous bit is sampled.
  - `locked_o` rises the cycle after the `LOCK_COUNT`-th consecutive match is sampled.
  - `locked_o` falls the cycle after the `ERR_THRESH`-th window error is sampled.
- Minimum time to lock from reset, with error-free input: `N` + `LOCK_COUNT` valid bits.
- Sustained throughput: one bit per clock.

## Structure
- Shared package `lfsr_pkg`:
  - `lfsr_state_t` enum: FILL, SEARCH, LOCKED.
  - Function `lfsr_feedback(state, taps)`, returning the XOR-of-taps bit. The generator is to be refactored to use the same function.
- Single module; no sub-module is required.
- The window/threshold logic may be split out as `lfsr_err_window` if it is reused elsewhere.

## Test plan
All scenarios use N = 8, TAPS = 8'b00000011, LOCK_COUNT = 16, WINDOW = 64, ERR_THRESH = 8, and a stream from the generator model with start value 0x01.
- Clean continuous stream: `locked_o` rises exactly after the 24th valid bit. After 1000 locked bits, `bit_cnt_o` = 1000, `err_cnt_o` = 0, and `err_o` never pulses.
- Single bit flip while locked: exactly one `err_o` pulse and `err_cnt_o` = 1. The flywheel means no follow-on errors, and `locked_o` stays 1.
- 8 flips within one 64-bit window: `locked_o` falls the cycle after the 8th flip. Then 7 flips per window for 3 windows: lock is held.
- Constant-0 input for 500 bits: `locked_o` stays 0. Then switch to a valid stream: lock after 24 bits.
- `valid_i` toggled randomly at 50% duty: same lock point in valid-bit count and identical counts as the continuous run.
- Mid-lock checks:
  - `reset_i` pulse: outputs are zero immediately.
  - `clear_cnt_i` coincident with an error: `err_cnt_o` = 0 and `err_o` = 1.
  - Preload near saturation (force to all-ones minus 1): counts saturate at all-ones.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the Fibonacci LFSR generator and checker.
package lfsr_pkg;

  // Widest LFSR the shared feedback helper handles.
  localparam int LFSR_MAX_W = 64;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } lfsr_state_t;

  // XOR of the history bits selected by the tap mask; narrower LFSRs zero-extend both arguments.
  function automatic logic lfsr_feedback(input logic [LFSR_MAX_W-1:0] state,
                                         input logic [LFSR_MAX_W-1:0] taps);
    return ^(state & taps);
  endfunction

endpackage

// File: rtl/lfsr_err_window.sv
// Windowed error monitor: flags the bit on which the error count inside
// the current WINDOW-bit window reaches ERR_THRESH.
module lfsr_err_window #(
  parameter int WINDOW     = 64,
  parameter int ERR_THRESH = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic bit_i,
  input  logic err_i,
  output logic thresh_o
);

  localparam int WB_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int WE_W = $clog2(ERR_THRESH + 1);

  logic [WB_W-1:0] win_bit_q, win_bit_d;
  logic [WE_W-1:0] win_err_q, win_err_d;
  logic            last_bit;

  // Threshold detect and window advance; loss of lock wins over the wrap.
  always_comb begin
    last_bit  = (win_bit_q == WB_W'(WINDOW - 1));
    thresh_o  = bit_i & err_i & (win_err_q == WE_W'(ERR_THRESH - 1));
    win_bit_d = win_bit_q;
    win_err_d = win_err_q;
    if (clear_i) begin
      win_bit_d = '0;
      win_err_d = '0;
    end else if (bit_i) begin
      if (thresh_o || last_bit) begin
        win_bit_d = '0;
        win_err_d = '0;
      end else begin
        win_bit_d = win_bit_q + WB_W'(1);
        win_err_d = win_err_q + WE_W'(err_i);
      end
    end
  end

  // Window position and error count registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      win_bit_q <= '0;
      win_err_q <= '0;
    end else begin
      win_bit_q <= win_bit_d;
      win_err_q <= win_err_d;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// PRBS receive checker: self-synchronizes to a Fibonacci LFSR stream,
// then flywheels on its own prediction and reports bit errors and lock.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int             N          = 8,
  parameter logic [N-1:0]   TAPS       = 8'b00000011,
  parameter int             LOCK_COUNT = 16,
  parameter int             WINDOW     = 64,
  parameter int             ERR_THRESH = 8,
  parameter int             CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             data_i,
  input  logic             valid_i,
  input  logic             clear_cnt_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] bit_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int FC_W = $clog2(N + 1);
  localparam int MC_W = $clog2(LOCK_COUNT + 1);

  lfsr_state_t      state_q;
  logic [N-1:0]     h_q;
  logic [FC_W-1:0]  fill_cnt_q;
  logic [MC_W-1:0]  match_cnt_q;
  logic             locked_q;
  logic             err_q;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic pred;
  logic search_hit;
  logic lock_bit;
  logic lock_err;
  logic lock_enter;
  logic lose_lock;

  // Prediction, per-bit classification and saturating statistics next-state.
  always_comb begin
    pred       = lfsr_feedback(LFSR_MAX_W'(h_q), LFSR_MAX_W'(TAPS));
    // An all-zero history would trivially predict a stuck-at-0 line, so it never matches.
    search_hit = (data_i == pred) && (|h_q);
    lock_bit   = valid_i && (state_q == LOCKED);
    lock_err   = lock_bit && (data_i != pred);
    lock_enter = valid_i && (state_q == SEARCH) && search_hit &&
                 (match_cnt_q == MC_W'(LOCK_COUNT - 1));
    bit_cnt_d  = bit_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (clear_cnt_i) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end else begin
      if (lock_bit && !(&bit_cnt_q)) bit_cnt_d = bit_cnt_q + CNT_W'(1);
      if (lock_err && !(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  lfsr_err_window #(
    .WINDOW     (WINDOW),
    .ERR_THRESH (ERR_THRESH)
  ) u_err_window (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (lock_enter),
    .bit_i    (lock_bit),
    .err_i    (lock_err),
    .thresh_o (lose_lock)
  );

  // Fill / search / flywheel sequencing with registered lock and error outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= FILL;
      h_q         <= '0;
      fill_cnt_q  <= '0;
      match_cnt_q <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= lock_err;
      if (valid_i) begin
        case (state_q)
          FILL: begin
            h_q <= {data_i, h_q[N-1:1]};
            if (fill_cnt_q == FC_W'(N - 1)) begin
              state_q     <= SEARCH;
              fill_cnt_q  <= '0;
              match_cnt_q <= '0;
            end else begin
              fill_cnt_q <= fill_cnt_q + FC_W'(1);
            end
          end
          SEARCH: begin
            h_q <= {data_i, h_q[N-1:1]};
            if (lock_enter) begin
              state_q     <= LOCKED;
              locked_q    <= 1'b1;
              match_cnt_q <= '0;
            end else if (search_hit) begin
              match_cnt_q <= match_cnt_q + MC_W'(1);
            end else begin
              match_cnt_q <= '0;
            end
          end
          LOCKED: begin
            // Flywheel: a line error must not corrupt the history.
            h_q <= {pred, h_q[N-1:1]};
            if (lose_lock) begin
              state_q    <= FILL;
              locked_q   <= 1'b0;
              fill_cnt_q <= '0;
            end
          end
          default: begin
            state_q  <= FILL;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Statistics counters.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign locked_o  = locked_q;
  assign err_o     = err_q;
  assign bit_cnt_o = bit_cnt_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a sequence-level reference model
// predicts every cycle's outputs; a monitor compares them.
module tb_lfsr_checker;

  localparam int       N          = 8;
  localparam logic [7:0] TB_TAPS  = 8'b00000011;
  localparam int       LOCK_COUNT = 16;
  localparam int       WINDOW     = 64;
  localparam int       ERR_THRESH = 8;
  localparam int       GEN_START  = 1;
  localparam longint   SAT_W      = 64'hFFFF_FFFF;
  localparam longint   SAT_S      = 15;

  localparam int M_FILL = 0, M_SEARCH = 1, M_LOCKED = 2;

  typedef struct packed {
    logic        locked;
    logic        err;
    logic [31:0] bc;
    logic [31:0] ec;
    logic        locked_s;
    logic        err_s;
    logic [3:0]  bcs;
    logic [3:0]  ecs;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        data_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        clear_cnt_i = 1'b0;
  logic        locked_o, err_o, locked_s, err_s;
  logic [31:0] bit_cnt_o, err_cnt_o;
  logic [3:0]  bit_cnt_s, err_cnt_s;

  int n_checks = 0;
  int n_errors = 0;
  int err_pulses = 0;

  rec_t sb[$];

  lfsr_checker #(.N(N), .TAPS(TB_TAPS), .LOCK_COUNT(LOCK_COUNT), .WINDOW(WINDOW),
                 .ERR_THRESH(ERR_THRESH), .CNT_W(32)) dut (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
    .clear_cnt_i(clear_cnt_i), .locked_o(locked_o), .err_o(err_o),
    .bit_cnt_o(bit_cnt_o), .err_cnt_o(err_cnt_o));

  // Narrow-counter copy on the same inputs exercises saturation.
  lfsr_checker #(.N(N), .TAPS(TB_TAPS), .LOCK_COUNT(LOCK_COUNT), .WINDOW(WINDOW),
                 .ERR_THRESH(ERR_THRESH), .CNT_W(4)) dut_s (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
    .clear_cnt_i(clear_cnt_i), .locked_o(locked_s), .err_o(err_s),
    .bit_cnt_o(bit_cnt_s), .err_cnt_o(err_cnt_s));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stream generator (start value 0x01, emits oldest bit)
  bit g_q[$];

  task automatic gen_restart();
    g_q = {};
    for (int i = 0; i < N; i++) g_q.push_back(bit'((GEN_START >> i) & 1));
  endtask

  function automatic bit gen_bit();
    bit o, fb;
    o  = g_q[0];
    fb = 1'b0;
    for (int i = 0; i < N; i++) fb ^= g_q[i] & TB_TAPS[i];
    void'(g_q.pop_front());
    g_q.push_back(fb);
    return o;
  endfunction

  // ---------------- reference model
  bit     m_h[$];
  int     m_mode, m_fill, m_run, m_wpos, m_werr;
  longint m_bits, m_errs;

  task automatic model_reset();
    m_h = {};
    for (int i = 0; i < N; i++) m_h.push_back(1'b0);
    m_mode = M_FILL; m_fill = 0; m_run = 0; m_wpos = 0; m_werr = 0;
    m_bits = 0; m_errs = 0;
  endtask

  function automatic bit model_pred();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) p ^= m_h[i] & TB_TAPS[i];
    return p;
  endfunction

  function automatic bit model_nonzero();
    bit nz = 1'b0;
    for (int i = 0; i < N; i++) nz |= m_h[i];
    return nz;
  endfunction

  task automatic model_shift(input bit b);
    void'(m_h.pop_front());
    m_h.push_back(b);
  endtask

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step(input bit v, input bit d, input bit c);
    bit   p, e;
    rec_t r;
    e = 1'b0;
    if (v) begin
      p = model_pred();
      if (m_mode == M_FILL) begin
        model_shift(d);
        m_fill++;
        if (m_fill == N) begin m_mode = M_SEARCH; m_run = 0; end
      end else if (m_mode == M_SEARCH) begin
        if (d == p && model_nonzero()) m_run++; else m_run = 0;
        model_shift(d);
        if (m_run == LOCK_COUNT) begin m_mode = M_LOCKED; m_wpos = 0; m_werr = 0; end
      end else begin
        m_bits++;
        if (d != p) begin e = 1'b1; m_errs++; m_werr++; end
        model_shift(p);
        if (m_werr == ERR_THRESH) begin
          m_mode = M_FILL; m_fill = 0;
        end else begin
          m_wpos++;
          if (m_wpos == WINDOW) begin m_wpos = 0; m_werr = 0; end
        end
      end
    end
    if (c) begin m_bits = 0; m_errs = 0; end
    r.locked   = (m_mode == M_LOCKED);
    r.err      = e;
    r.bc       = 32'(sat(m_bits, SAT_W));
    r.ec       = 32'(sat(m_errs, SAT_W));
    r.locked_s = r.locked;
    r.err_s    = e;
    r.bcs      = 4'(sat(m_bits, SAT_S));
    r.ecs      = 4'(sat(m_errs, SAT_S));
    sb.push_back(r);
  endtask

  // ---------------- monitor
  always @(posedge clk) begin
    rec_t exp_r, act_r;
    #1;
    if (sb.size() > 0) begin
      exp_r = sb.pop_front();
      act_r = {locked_o, err_o, bit_cnt_o, err_cnt_o, locked_s, err_s, bit_cnt_s, err_cnt_s};
      n_checks++;
      if (act_r !== exp_r) begin
        n_errors++;
        $display("FAIL cycle t=%0t got locked=%0d err=%0d bc=%0d ec=%0d lk_s=%0d err_s=%0d bcs=%0d ecs=%0d want locked=%0d err=%0d bc=%0d ec=%0d lk_s=%0d err_s=%0d bcs=%0d ecs=%0d",
                 $time, act_r.locked, act_r.err, act_r.bc, act_r.ec, act_r.locked_s, act_r.err_s,
                 act_r.bcs, act_r.ecs, exp_r.locked, exp_r.err, exp_r.bc, exp_r.ec,
                 exp_r.locked_s, exp_r.err_s, exp_r.bcs, exp_r.ecs);
      end
    end
    if (err_o === 1'b1) err_pulses++;
  end

  // ---------------- stimulus helpers
  task automatic chk(input string name, input longint act, input longint exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp_v);
    end
  endtask

  task automatic step(input bit v, input bit d, input bit c);
    @(negedge clk);
    valid_i = v; data_i = d; clear_cnt_i = c;
    model_step(v, d, c);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1; valid_i = 1'b0; clear_cnt_i = 1'b0; data_i = 1'b0;
    #1;
    chk("rst_locked", longint'(locked_o), 0);
    chk("rst_err", longint'(err_o), 0);
    chk("rst_bit_cnt", longint'(bit_cnt_o), 0);
    chk("rst_err_cnt", longint'(err_cnt_o), 0);
    model_reset();
    sb.push_back('0);
    @(posedge clk);
    #2;
    reset_i = 1'b0;
  endtask

  initial begin
    int p0, vcount;
    bit v, d;

    // Clean continuous stream
    do_reset();
    gen_restart();
    for (int k = 1; k <= 24; k++) begin
      step(1'b1, gen_bit(), 1'b0);
      if (k == 23) chk("pre_lock_23", longint'(locked_o), 0);
      if (k == 24) chk("lock_at_24", longint'(locked_o), 1);
    end
    for (int k = 0; k < 1000; k++) step(1'b1, gen_bit(), 1'b0);
    chk("clean_bit_cnt", longint'(bit_cnt_o), 1000);
    chk("clean_err_cnt", longint'(err_cnt_o), 0);
    chk("clean_err_pulses", longint'(err_pulses), 0);

    // Single flip while locked
    step(1'b0, 1'b0, 1'b1);
    p0 = err_pulses;
    for (int k = 0; k < 50; k++) step(1'b1, gen_bit() ^ (k == 20), 1'b0);
    chk("flip1_pulses", longint'(err_pulses - p0), 1);
    chk("flip1_err_cnt", longint'(err_cnt_o), 1);
    chk("flip1_bit_cnt", longint'(bit_cnt_o), 50);
    chk("flip1_locked", longint'(locked_o), 1);

    // 8 flips in one window lose lock, then 7 per window hold it
    do_reset();
    gen_restart();
    for (int k = 0; k < 24; k++) step(1'b1, gen_bit(), 1'b0);
    for (int j = 0; j <= 56; j++) begin
      step(1'b1, gen_bit() ^ (j >= 4 && j <= 32 && (j % 4) == 0), 1'b0);
      if (j == 31) chk("thresh_pre", longint'(locked_o), 1);
      if (j == 32) chk("thresh_lost", longint'(locked_o), 0);
      if (j == 55) chk("relock_pre", longint'(locked_o), 0);
      if (j == 56) chk("relock", longint'(locked_o), 1);
    end
    for (int w = 0; w < 3; w++)
      for (int k = 0; k < WINDOW; k++)
        step(1'b1, gen_bit() ^ (k >= 10 && k <= 40 && (k % 5) == 0), 1'b0);
    chk("seven_held", longint'(locked_o), 1);
    chk("seven_err_cnt", longint'(err_cnt_o), 29);
    chk("sat_err_cnt", longint'(err_cnt_s), 15);
    chk("sat_bit_cnt", longint'(bit_cnt_s), 15);

    // Stuck-at-0 never locks, then a real stream locks in 24 bits
    do_reset();
    for (int k = 0; k < 500; k++) step(1'b1, 1'b0, 1'b0);
    chk("zero_no_lock", longint'(locked_o), 0);
    gen_restart();
    for (int k = 1; k <= 24; k++) begin
      step(1'b1, gen_bit(), 1'b0);
      if (k == 23) chk("zero_relock_pre", longint'(locked_o), 0);
      if (k == 24) chk("zero_relock", longint'(locked_o), 1);
    end

    // 50% random valid
    do_reset();
    gen_restart();
    vcount = 0;
    p0 = err_pulses;
    while (vcount < 1024) begin
      v = 1'($urandom_range(1, 0));
      d = v ? gen_bit() : 1'($urandom_range(1, 0));
      step(v, d, 1'b0);
      if (v) begin
        vcount++;
        if (vcount == 23) chk("rv_pre_lock", longint'(locked_o), 0);
        if (vcount == 24) chk("rv_lock_24", longint'(locked_o), 1);
      end
    end
    chk("rv_bit_cnt", longint'(bit_cnt_o), 1000);
    chk("rv_err_cnt", longint'(err_cnt_o), 0);
    chk("rv_err_pulses", longint'(err_pulses - p0), 0);

    // Clear coincident with an error, then reset mid-lock
    step(1'b1, gen_bit() ^ 1'b1, 1'b1);
    chk("clr_err_o", longint'(err_o), 1);
    chk("clr_err_cnt", longint'(err_cnt_o), 0);
    chk("clr_bit_cnt", longint'(bit_cnt_o), 0);
    step(1'b1, gen_bit(), 1'b0);
    chk("clr_locked", longint'(locked_o), 1);
    do_reset();

    // Random traffic with sparse flips and clears
    gen_restart();
    for (int k = 0; k < 3000; k++) begin
      v = ($urandom_range(3, 0) != 0);
      d = v ? (gen_bit() ^ ($urandom_range(39, 0) == 0)) : 1'($urandom_range(1, 0));
      step(v, d, $urandom_range(499, 0) == 0);
    end

    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("sb_drained", longint'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
